multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM for the RV32 datapath. It sequences fetch, decode, execute, memory and writeback for lw, sw, beq/bne and R-/I-type ALU instructions. It drives the shared-memory handshake, PC/IR write enables, ALU operand and operation selects, and writeback selects. It sits between the instruction register (opcode/funct3 from IR) and the datapath that also contains the immediate generator.

## Interface

Parameters:
- CNT_W, 32: width of retired-instruction counter

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address: 0 PC, 1 ALUOut register
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 sub, 10 decode from funct fields
- result_src  out  2  00 ALUOut register, 01 memory data register, 10 ALU result
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state encoding (debug)
- instret  out  CNT_W  retired-instruction count

## Operation

- Supported opcodes: 0000011 lw, 0100011 sw, 1100011 branch, 0110011 R-type, 0010011 I-type ALU.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, HALT 10.
- Outputs are combinational decodes of state, mem_ready, zero and funct3. Unlisted outputs are 0.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, op=00, result_src=10. While mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: a=01, b=01, op=00 (branch target into ALUOut).
  - lw/sw -> MEMADR; R -> EXECR; I -> EXECI; branch -> BRANCH.
  - Any other opcode -> HALT, and illegal is set.
- MEMADR: a=10, b=01, op=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB, else stay.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready go to FETCH, else stay.
- EXECR: a=10, b=00, op=10 -> ALUWB. EXECI: a=10, b=01, op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, then go to FETCH.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Any other funct3 is not taken and is not illegal.
- HALT: all strobes 0; stays until reset.
- instret increments by 1 on each retiring transition into FETCH (from MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready). It wraps from 2^CNT_W-1 to 0.

## Timing

- Reset (rst_n low, asynchronous): state=FETCH, illegal=0, instret=0.
  - mem_req, mem_we, ir_write, pc_write and reg_write are forced 0 while rst_n is low.
  - The first fetch request appears in the first cycle after release.
- Reset mid-instruction aborts the instruction; no retire is counted.
- Handshake rules:
  - mem_req and adr_src stay stable from assertion through the cycle with mem_ready=1 inclusive.
  - mem_ready while mem_req=0 is ignored.
  - Each wait cycle adds exactly 1 cycle.
- Zero-wait latency per instruction: lw 5, sw 4, R/I 4, branch 3 cycles.
- illegal asserts the cycle after DECODE sees the bad opcode and never clears except by reset.

## Test plan

- Reset release, mem_ready tied 1, lw stream -> state sequence 0,1,2,3,4,0. reg_write high only in state 4. instret=1 after 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_req/mem_we/adr_src=1 held for 4 cycles. Total 7 cycles; no reg_write.
- Branches:
  - beq with zero=1 -> pc_write=1 in BRANCH; 3 cycles.
  - bne with zero=1 -> pc_write=0.
  - funct3=100 -> pc_write=0, illegal=0.
- R-type then I-type back-to-back -> alu_src_b 00 then 01 in the EXEC state. alu_op=10. 8 cycles total, instret=2.
- Opcode 1111111 -> HALT (state 10) from the cycle after DECODE, illegal=1, no mem_req. After rst_n pulse: illegal=0, state=0.
- Preload-free wrap: CNT_W=3, retire 9 R-types -> instret reads 1. Assert rst_n low during MEMREAD -> strobes 0 immediately and instret=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and the RV32 datapath.
// Carries the IR fields and ALU flag into the controller, the memory
// handshake, and every datapath strobe/select out of it.
//   master : controller side (drives strobes and selects)
//   slave  : datapath/memory side (drives IR fields, zero, mem_ready)
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal, state, instret
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32 datapath: sequences fetch, decode,
// execute, memory and writeback for lw, sw, beq/bne and R/I ALU ops.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of multicycle_control_if (IR fields, zero flag,
//           memory handshake, datapath strobes/selects, illegal flag,
//           debug state, retired-instruction counter)
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;

    logic       retire_c;
    logic       set_illegal_c;
    logic       mem_req_c;
    logic       mem_we_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] result_src_c;

    // Next-state and output decode; outputs depend on state plus the
    // same-cycle mem_ready, zero and funct3 inputs.
    always_comb begin
        state_d       = state_q;
        retire_c      = 1'b0;
        set_illegal_c = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        adr_src_c     = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a_c   = 2'b00;
        alu_src_b_c   = 2'b00;
        alu_op_c      = 2'b00;
        result_src_c  = 2'b00;

        case (state_q)
            FETCH: begin
                // PC + 4 computed on the ALU and routed straight to the PC.
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                // oldPC + imm lands in ALUOut as the branch target.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BRANCH;
                    default: begin
                        state_d       = HALT;
                        set_illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                // Compare rs1 - rs2; target already sits in ALUOut.
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_write_c  = ((bus.funct3 == F3_BEQ) &&  bus.zero) ||
                              ((bus.funct3 == F3_BNE) && !bus.zero);
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal_c) begin
                illegal_q <= 1'b1;
            end
            if (retire_c) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Reset holds state at FETCH, so strobes are gated to stay quiet while rst_n is low.
    assign bus.mem_req    = mem_req_c   & rst_n;
    assign bus.mem_we     = mem_we_c    & rst_n;
    assign bus.ir_write   = ir_write_c  & rst_n;
    assign bus.pc_write   = pc_write_c  & rst_n;
    assign bus.reg_write  = reg_write_c & rst_n;
    assign bus.adr_src    = adr_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.result_src = result_src_c;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table,
// hand-written reset/illegal/wrap sequences, and randomized instruction
// streams checked against an instruction-level reference model.
module tb_multicycle_control;

    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MOD = 1 << CNT_W;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;

    typedef enum int {K_LW, K_SW, K_BR, K_R, K_I, K_BAD} kind_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        bit         z;
        int         wf;
        int         wm;
        int         cyc;
        int         regw;
        int         pcw;
        int         memreq;
        int         memwe;
        logic [1:0] exec_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_instret = 0;

    int obs_q[$];
    int exp_q[$];
    int r_cyc, r_regw, r_pcw, r_memreq, r_memwe, r_irw, r_viol;
    logic [1:0] r_exec_a, r_exec_b, r_exec_op;
    logic r_ill_dec, r_ill_halt;
    bit   r_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [6:0] op);
        case (op)
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_BR:   return K_BR;
            OP_R:    return K_R;
            OP_I:    return K_I;
            default: return K_BAD;
        endcase
    endfunction

    // Reference phase list for one instruction: fetch (plus waits), decode,
    // then the instruction-specific phases. Illegal ops show three HALT cycles.
    function automatic void build_exp(input kind_t k, input int wf, input int wm);
        exp_q.delete();
        repeat (wf + 1) exp_q.push_back(0);
        exp_q.push_back(1);
        case (k)
            K_LW: begin
                exp_q.push_back(2);
                repeat (wm + 1) exp_q.push_back(3);
                exp_q.push_back(4);
            end
            K_SW: begin
                exp_q.push_back(2);
                repeat (wm + 1) exp_q.push_back(5);
            end
            K_BR: exp_q.push_back(9);
            K_R: begin
                exp_q.push_back(6);
                exp_q.push_back(8);
            end
            K_I: begin
                exp_q.push_back(7);
                exp_q.push_back(8);
            end
            default: repeat (3) exp_q.push_back(10);
        endcase
    endfunction

    // Runs one instruction starting at a negedge; returns at the negedge that
    // begins the next fetch (or after three HALT cycles).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit z,
                             input int wf, input int wm);
        int  st;
        int  prev;
        int  idx;
        int  w;
        int  n_halt;
        bit  seen;
        obs_q.delete();
        r_cyc = 0; r_regw = 0; r_pcw = 0; r_memreq = 0; r_memwe = 0; r_irw = 0; r_viol = 0;
        r_exec_a = 2'b11; r_exec_b = 2'b11; r_exec_op = 2'b11;
        r_ill_dec = 1'bx; r_ill_halt = 1'bx; r_timeout = 1'b0;
        prev = -1; idx = 0; n_halt = 0; seen = 1'b0;
        bus.opcode = op;
        bus.funct3 = f3;
        bus.zero   = z;
        while (1) begin
            st = int'(bus.state);
            if (seen && st == 0) break;
            if (n_halt == 3) break;
            if (r_cyc >= 60) begin
                r_timeout = 1'b1;
                break;
            end
            idx = (st == prev) ? idx + 1 : 0;
            w   = (st == 0) ? wf : wm;
            if (st == 0 || st == 3 || st == 5) bus.mem_ready = (idx == w);
            else                               bus.mem_ready = 1'($urandom);
            #1;
            obs_q.push_back(st);
            r_cyc++;
            r_regw   += int'(bus.reg_write);
            r_pcw    += int'(bus.pc_write);
            r_memreq += int'(bus.mem_req);
            r_memwe  += int'(bus.mem_we);
            r_irw    += int'(bus.ir_write);
            if (bus.mem_req !== 1'(st == 0 || st == 3 || st == 5)) r_viol++;
            if (bus.mem_req === 1'b1 && bus.adr_src !== 1'(st != 0)) r_viol++;
            if (bus.mem_we !== 1'(st == 5)) r_viol++;
            if (bus.reg_write === 1'b1 && !(st == 4 || st == 8)) r_viol++;
            if (bus.ir_write === 1'b1 && st != 0) r_viol++;
            if (bus.pc_write === 1'b1 && !(st == 0 || st == 9)) r_viol++;
            if (st == 6 || st == 7) begin
                r_exec_a  = bus.alu_src_a;
                r_exec_b  = bus.alu_src_b;
                r_exec_op = bus.alu_op;
            end
            if (st == 1) r_ill_dec = bus.illegal;
            if (st == 10 && n_halt == 0) r_ill_halt = bus.illegal;
            prev = st;
            if (st != 0) seen = 1'b1;
            if (st == 10) n_halt++;
            @(negedge clk);
        end
        check("no_timeout", 32'(r_timeout), 0);
    endtask

    task automatic check_trace(input string name);
        int ndiff;
        ndiff = 0;
        check({name, "_len"}, obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            foreach (exp_q[i]) if (obs_q[i] != exp_q[i]) ndiff++;
        end
        check({name, "_diff"}, ndiff, 0);
    endtask

    // Reset pulse from a negedge: checks the asynchronous effect immediately.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_ir_write", 32'(bus.ir_write), 0);
        check("rst_pc_write", 32'(bus.pc_write), 0);
        check("rst_state", 32'(bus.state), 0);
        check("rst_illegal", 32'(bus.illegal), 0);
        check("rst_instret", 32'(bus.instret), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
    endtask

    initial begin
        vec_t  tbl[9];
        kind_t k;
        logic [6:0] op;
        logic [2:0] f3;
        bit    z;
        int    wf, wm, st;
        int    taken;

        tbl[0] = '{OP_LW, 3'b010, 1'b0, 0, 0, 5, 1, 1, 2, 0, 2'b00};
        tbl[1] = '{OP_SW, 3'b010, 1'b0, 0, 3, 7, 0, 1, 5, 4, 2'b00};
        tbl[2] = '{OP_BR, 3'b000, 1'b1, 0, 0, 3, 0, 2, 1, 0, 2'b00};
        tbl[3] = '{OP_BR, 3'b001, 1'b1, 0, 0, 3, 0, 1, 1, 0, 2'b00};
        tbl[4] = '{OP_BR, 3'b100, 1'b1, 0, 0, 3, 0, 1, 1, 0, 2'b00};
        tbl[5] = '{OP_R,  3'b000, 1'b0, 0, 0, 4, 1, 1, 1, 0, 2'b00};
        tbl[6] = '{OP_I,  3'b000, 1'b0, 0, 0, 4, 1, 1, 1, 0, 2'b01};
        tbl[7] = '{OP_LW, 3'b010, 1'b1, 2, 1, 8, 1, 1, 5, 0, 2'b00};
        tbl[8] = '{OP_BR, 3'b001, 1'b0, 1, 0, 4, 0, 2, 2, 0, 2'b00};

        bus.opcode = OP_LW; bus.funct3 = 3'b000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("init_mem_req", 32'(bus.mem_req), 0);
        check("init_reg_write", 32'(bus.reg_write), 0);
        check("init_state", 32'(bus.state), 0);
        check("init_illegal", 32'(bus.illegal), 0);
        check("init_instret", 32'(bus.instret), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_fetch_req", 32'(bus.mem_req), 1);

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].wf, tbl[i].wm);
            build_exp(kind_of(tbl[i].op), tbl[i].wf, tbl[i].wm);
            check_trace($sformatf("vec%0d_trace", i));
            check($sformatf("vec%0d_cycles", i), r_cyc, tbl[i].cyc);
            check($sformatf("vec%0d_reg_write", i), r_regw, tbl[i].regw);
            check($sformatf("vec%0d_pc_write", i), r_pcw, tbl[i].pcw);
            check($sformatf("vec%0d_mem_req", i), r_memreq, tbl[i].memreq);
            check($sformatf("vec%0d_mem_we", i), r_memwe, tbl[i].memwe);
            check($sformatf("vec%0d_ir_write", i), r_irw, 1);
            check($sformatf("vec%0d_strobe_rules", i), r_viol, 0);
            if (tbl[i].op == OP_R || tbl[i].op == OP_I) begin
                check($sformatf("vec%0d_exec_b", i), 32'(r_exec_b), 32'(tbl[i].exec_b));
                check($sformatf("vec%0d_exec_op", i), 32'(r_exec_op), 2);
                check($sformatf("vec%0d_exec_a", i), 32'(r_exec_a), 2);
            end
            exp_instret = (exp_instret + 1) % CNT_MOD;
            check($sformatf("vec%0d_instret", i), 32'(bus.instret), exp_instret);
            check($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 0);
        end

        // Unsupported opcode halts and sets the sticky flag.
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        build_exp(K_BAD, 0, 0);
        check_trace("halt_trace");
        check("halt_mem_req", r_memreq, 1);
        check("halt_ill_at_decode", 32'(r_ill_dec), 0);
        check("halt_ill_first", 32'(r_ill_halt), 1);
        check("halt_state", 32'(bus.state), 10);
        check("halt_illegal", 32'(bus.illegal), 1);
        check("halt_instret", 32'(bus.instret), exp_instret);
        reset_pulse();
        check("post_rst_state", 32'(bus.state), 0);

        // Counter wrap: nine retires on a 3-bit counter.
        for (int i = 0; i < 9; i++) begin
            run_instr(OP_R, 3'b000, 1'b0, 0, 0);
            exp_instret = (exp_instret + 1) % CNT_MOD;
        end
        check("wrap_instret", 32'(bus.instret), 1);

        // Reset asserted mid-MEMREAD aborts without retiring.
        bus.opcode = OP_LW;
        st = int'(bus.state);
        for (int c = 0; c < 10 && st != 3; c++) begin
            bus.mem_ready = (st == 0);
            @(negedge clk);
            st = int'(bus.state);
        end
        check("reach_memread", st, 3);
        bus.mem_ready = 1'b0;
        #1;
        check("memread_req", 32'(bus.mem_req), 1);
        check("memread_adr", 32'(bus.adr_src), 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(bus.mem_req), 0);
        check("abort_mem_we", 32'(bus.mem_we), 0);
        check("abort_reg_write", 32'(bus.reg_write), 0);
        check("abort_pc_write", 32'(bus.pc_write), 0);
        check("abort_state", 32'(bus.state), 0);
        check("abort_instret", 32'(bus.instret), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 19))
                0:        k = K_BAD;
                1, 2, 3:  k = K_LW;
                4, 5, 6:  k = K_SW;
                7, 8, 9, 10, 11: k = K_BR;
                12, 13, 14, 15:  k = K_R;
                default:  k = K_I;
            endcase
            case (k)
                K_LW: op = OP_LW;
                K_SW: op = OP_SW;
                K_BR: op = OP_BR;
                K_R:  op = OP_R;
                K_I:  op = OP_I;
                default: begin
                    op = 7'($urandom);
                    if (kind_of(op) != K_BAD) op = 7'b1111111;
                end
            endcase
            f3 = 3'($urandom);
            z  = 1'($urandom);
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            run_instr(op, f3, z, wf, wm);
            build_exp(k, wf, wm);
            check_trace("rnd_trace");
            check("rnd_strobe_rules", r_viol, 0);
            check("rnd_ir_write", r_irw, 1);
            check("rnd_reg_write", r_regw, (k == K_LW || k == K_R || k == K_I) ? 1 : 0);
            taken = (k == K_BR && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z))) ? 1 : 0;
            check("rnd_pc_write", r_pcw, 1 + taken);
            check("rnd_mem_req", r_memreq, wf + 1 + ((k == K_LW || k == K_SW) ? wm + 1 : 0));
            check("rnd_mem_we", r_memwe, (k == K_SW) ? wm + 1 : 0);
            if (k == K_R || k == K_I) begin
                check("rnd_exec_b", 32'(r_exec_b), (k == K_I) ? 1 : 0);
                check("rnd_exec_op", 32'(r_exec_op), 2);
            end
            if (k == K_BAD) begin
                check("rnd_halt_illegal", 32'(bus.illegal), 1);
                check("rnd_halt_instret", 32'(bus.instret), exp_instret);
                reset_pulse();
            end else begin
                exp_instret = (exp_instret + 1) % CNT_MOD;
                check("rnd_instret", 32'(bus.instret), exp_instret);
                check("rnd_illegal", 32'(bus.illegal), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
